// File: rtl/instructions_pkg.sv
// Shared core constants, plus the write-back arbiter defaults and its buffer entry type.
package instructions_pkg;
  localparam int XLEN          = 32;
  // Width of a register-file index (32 architectural registers).
  localparam int MSB_REG_FILE  = 5;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_STARVE_MAX = 4;

  typedef struct packed {
    logic [MSB_REG_FILE-1:0] rd;
    logic [XLEN-1:0]         data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Strict FIFO holding long-latency results; exports per-entry valid/rd for hazard tracking.
module wb_fifo
  import instructions_pkg::*;
#(
  parameter  int DEPTH = WB_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic                                pop,
  input  wb_entry_t                           push_entry,
  output wb_entry_t                           head,
  output logic                                full,
  output logic                                empty,
  output logic [AW:0]                         count,
  output logic [DEPTH-1:0]                    ent_vld,
  output logic [DEPTH-1:0][MSB_REG_FILE-1:0]  ent_rd
);
  wb_entry_t        mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic [DEPTH-1:0] vld_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rptr_q];
  assign ent_vld = vld_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem_q[i].rd;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      if (do_push) begin
        vld_q[wptr_q] <= 1'b1;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + 1'b1;
      end
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_entry;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU has priority, long-latency results are buffered
// and drained on idle ALU cycles or forcibly after a bounded starvation window.
module wb_arbiter
  import instructions_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [MSB_REG_FILE-1:0] alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    lu_valid,
  output logic                    lu_ready,
  input  logic [MSB_REG_FILE-1:0] lu_rd,
  input  logic [XLEN-1:0]         lu_data,
  output logic                    CtrlWriteEn,
  output logic [MSB_REG_FILE-1:0] rd_Ps6,
  output logic [XLEN-1:0]         DataRd,
  output logic                    stall_req,
  output logic [31:0]             pending_mask
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_entry_t                              head;
  logic                                   full, empty, pop;
  logic [AW:0]                            count;
  logic [FIFO_DEPTH-1:0]                  ent_vld;
  logic [FIFO_DEPTH-1:0][MSB_REG_FILE-1:0] ent_rd;

  logic [SW-1:0]           starve_q, starve_d;
  logic                    we_q, we_d;
  logic [MSB_REG_FILE-1:0] rd_q, rd_d;
  logic [XLEN-1:0]         data_q, data_d;

  assign pop      = !alu_valid && !empty;
  assign lu_ready = !full;
  assign stall_req = (starve_q == SW'(STARVE_MAX));

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (lu_valid),
    .pop        (pop),
    .push_entry ({lu_rd, lu_data}),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .ent_vld    (ent_vld),
    .ent_rd     (ent_rd)
  );

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_vld[i]) pending_mask[ent_rd[i]] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  // Writes to r0 are swallowed: no pulse, and the visible address/data hold.
  always_comb begin
    we_d     = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    starve_d = starve_q;
    if (alu_valid) begin
      if (alu_rd != '0) begin
        we_d   = 1'b1;
        rd_d   = alu_rd;
        data_d = alu_data;
      end
    end else if (!empty && head.rd != '0) begin
      we_d   = 1'b1;
      rd_d   = head.rd;
      data_d = head.data;
    end
    if (pop || empty)                          starve_d = '0;
    else if (alu_valid && !stall_req)          starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      starve_q <= '0;
    end else begin
      we_q     <= we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      starve_q <= starve_d;
    end
  end

  assign CtrlWriteEn = we_q;
  assign rd_Ps6      = rd_q;
  assign DataRd      = data_q;

  a_no_alu_in_stall: assert property (@(posedge clk) disable iff (rst)
    !(alu_valid && stall_req));
  a_no_waw: assert property (@(posedge clk) disable iff (rst)
    !(alu_valid && alu_rd != '0 && pending_mask[alu_rd]));

  logic unused_ok;
  assign unused_ok = ^count;
endmodule
